// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch stage: default width, fetch FSM states
// and the packing width of a {pc, instr} queue entry.
package pipe_pkg;

    localparam int XLEN_DEFAULT = 32;

    // A queue entry carries the PC in the upper half and the instruction below it.
    localparam int FETCH_ENTRY_W = 2 * XLEN_DEFAULT;

    typedef enum logic [1:0] {
        FETCH_ISSUE = 2'd0,  // may present a request to instruction memory
        FETCH_WAIT  = 2'd1,  // one request accepted, response pending
        FETCH_DRAIN = 2'd2   // redirected while waiting; next response is stale
    } fetch_state_e;

    function automatic int fetch_entry_width(input int xlen);
        return 2 * xlen;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries for decode.
// Flush empties it in one cycle; push and pop may coincide even when full.
module fetch_queue
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FETCH_ENTRY_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (PTR_W + 1)'(DEPTH));
    assign count     = count_reg;
    assign do_pop    = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr_reg];

    // Entry storage; stale slots are never presented, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one request in flight
// to instruction memory, and queues {pc, instr} pairs for decode. A redirect
// flushes the queue, withdraws or drains the in-flight request and retargets.
module fetch_unit
    import pipe_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              Q_DEPTH  = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] PC_STEP  = XLEN'(4)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_next
);

    localparam int ENTRY_W = fetch_entry_width(XLEN);
    localparam int CNT_W   = $clog2(Q_DEPTH) + 1;

    fetch_state_e     state_reg;
    fetch_state_e     state_next;
    logic [XLEN-1:0]  pc_reg;
    logic [XLEN-1:0]  pc_next;
    logic [XLEN-1:0]  req_pc_reg;
    logic             req_fire;
    logic             rsp_push;
    logic             deq;
    logic [ENTRY_W-1:0] head_entry;
    logic             q_full;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;

    // Only request when a queue slot is free for the response; a redirect or
    // reset withdraws the request so it can never be accepted that cycle.
    assign imem_req_valid = (state_reg == FETCH_ISSUE)
                         && (q_count < CNT_W'(Q_DEPTH))
                         && !redirect_valid
                         && !rst;
    assign imem_req_addr  = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses count only while waiting; in ISSUE they are protocol errors
    // and in DRAIN they belong to the pre-redirect stream.
    assign rsp_push = (state_reg == FETCH_WAIT) && imem_rsp_valid && !redirect_valid
                   && (!q_full || deq);
    assign deq      = id_valid && id_ready && !redirect_valid;

    // Decode outputs read as zero whenever there is nothing to present.
    assign id_valid   = !q_empty;
    assign id_pc      = id_valid ? head_entry[ENTRY_W-1 -: XLEN] : '0;
    assign id_instr   = id_valid ? head_entry[XLEN-1:0] : '0;
    assign id_pc_next = id_valid ? (id_pc + PC_STEP) : '0;

    fetch_queue #(
        .DEPTH (Q_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_push),
        .push_data ({req_pc_reg, imem_rsp_data}),
        .pop       (deq),
        .head_data (head_entry),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // Fetch FSM transitions: the outstanding response always closes WAIT/DRAIN.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH_ISSUE: begin
                if (req_fire) begin
                    state_next = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    state_next = FETCH_ISSUE;
                end else if (redirect_valid) begin
                    state_next = FETCH_DRAIN;
                end
            end
            FETCH_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_next = FETCH_ISSUE;
                end
            end
            default: state_next = FETCH_ISSUE;
        endcase
    end

    // PC update: a redirect wins over the sequential advance on accept.
    always_comb begin
        pc_next = pc_reg;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (req_fire) begin
            pc_next = pc_reg + PC_STEP;
        end
    end

    // State, PC and the address of the in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= FETCH_ISSUE;
            pc_reg     <= RESET_PC;
            req_pc_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (req_fire) begin
                req_pc_reg <= pc_reg;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a cycle-driven memory responder plus a queue-level
// model of the fetch stream, checked every cycle, with directed scenarios
// followed by a randomized run.
module tb_fetch_unit;

    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_next;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (32),
        .Q_DEPTH  (QD),
        .RESET_PC (32'h0),
        .PC_STEP  (32'h4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_next     (id_pc_next)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Reference model: expected decode queue and fetch bookkeeping.
    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          outstanding;
    bit          stale;

    // Memory responder state.
    bit          mem_busy;
    int          mem_delay;
    logic [31:0] mem_addr;

    // Per-cycle knobs.
    bit          k_rst, k_redirect, k_junk, k_idr_force, k_chk_zero;
    logic [31:0] k_redirect_pc;
    int          ready_pct, idr_pct, min_delay, max_delay;

    logic [31:0] dut_deq[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_deq(input string tag, input int idx, input logic [31:0] exp);
        if (dut_deq.size() > idx) begin
            check(tag, dut_deq[idx], exp);
        end else begin
            checks++;
            errors++;
            $error("FAIL %s observed=missing(%0d dequeued) expected=%08h", tag, dut_deq.size(), exp);
        end
    endtask

    task automatic check_bound(input string tag, input int n, input int limit);
        checks++;
        assert (n < limit) else begin
            errors++;
            $error("FAIL %s observed=%0d cycles expected=<%0d", tag, n, limit);
        end
    endtask

    // One clock cycle: drive at negedge, check outputs, advance model and memory.
    task automatic cycle();
        bit exp_req, acc_dut, acc_exp, rsp, pop;
        @(negedge clk);
        rst            = k_rst;
        redirect_valid = k_redirect;
        redirect_pc    = k_redirect_pc;
        rsp            = (mem_busy && mem_delay == 0) || (k_junk && !mem_busy);
        imem_rsp_valid = rsp;
        imem_rsp_data  = mem_busy ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        imem_req_ready = !mem_busy && ($urandom_range(99) < ready_pct);
        id_ready       = k_idr_force || ($urandom_range(99) < idr_pct);
        #1;
        exp_req = !k_rst && !k_redirect && !outstanding && (q.size() < QD);
        check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
        if (exp_req) check("req_addr", imem_req_addr, m_pc);
        if (!k_rst) begin
            check("id_valid", {31'd0, id_valid}, {31'd0, q.size() > 0});
            if (q.size() > 0) begin
                check("id_pc", id_pc, q[0].pc);
                check("id_instr", id_instr, q[0].instr);
                check("id_pc_next", id_pc_next, q[0].pc + 32'd4);
            end else if (k_chk_zero) begin
                check("id_pc_zero", id_pc, 32'd0);
                check("id_instr_zero", id_instr, 32'd0);
            end
            if (!k_redirect && id_valid && id_ready) begin
                dut_deq.push_back(id_pc);
                $display("deq pc=%08h instr=%08h", id_pc, id_instr);
            end
        end
        acc_dut = imem_req_valid && imem_req_ready;
        acc_exp = exp_req && imem_req_ready;

        if (rsp && mem_busy) mem_busy = 0;
        else if (mem_busy) mem_delay--;
        if (acc_dut) begin
            mem_busy  = 1;
            mem_addr  = imem_req_addr;
            mem_delay = int'($urandom_range(max_delay, min_delay));
        end

        if (k_rst) begin
            q.delete();
            m_pc        = 32'h0;
            outstanding = 0;
            stale       = 0;
        end else if (k_redirect) begin
            q.delete();
            m_pc = k_redirect_pc;
            if (outstanding) begin
                if (rsp) begin
                    outstanding = 0;
                    stale       = 0;
                end else begin
                    stale = 1;
                end
            end
        end else begin
            pop = id_ready && (q.size() > 0);
            if (pop) void'(q.pop_front());
            if (rsp && outstanding) begin
                if (!stale) q.push_back('{pc: m_req_pc, instr: mem_word(m_req_pc)});
                outstanding = 0;
                stale       = 0;
            end
            if (acc_exp) begin
                outstanding = 1;
                m_req_pc    = m_pc;
                m_pc        = m_pc + 32'd4;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic redirect_once(input logic [31:0] pc);
        k_redirect    = 1;
        k_redirect_pc = pc;
        cycle();
        k_redirect  = 0;
        k_idr_force = 0;
        dut_deq.delete();
    endtask

    initial begin
        int n;
        rst = 1'b1; redirect_valid = 0; redirect_pc = '0; imem_req_ready = 0;
        imem_rsp_valid = 0; imem_rsp_data = '0; id_ready = 0;
        m_pc = 0; m_req_pc = 0; outstanding = 0; stale = 0;
        mem_busy = 0; mem_delay = 0; mem_addr = 0;
        k_rst = 1; k_redirect = 0; k_junk = 0; k_idr_force = 0; k_chk_zero = 0;
        k_redirect_pc = 0;
        ready_pct = 100; idr_pct = 100; min_delay = 0; max_delay = 0;

        // 1: reset for two cycles, then first request at address 0.
        run(2);
        k_rst = 0;
        k_chk_zero = 1;
        dut_deq.delete();
        cycle();
        k_chk_zero = 0;

        // 2: single-cycle memory, decode always ready: stream 0,4,8,12.
        run(12);
        check_deq("seq_pc0", 0, 32'h0);
        check_deq("seq_pc1", 1, 32'h4);
        check_deq("seq_pc2", 2, 32'h8);
        check_deq("seq_pc3", 3, 32'hC);

        // 3: decode stalls until the queue fills, then drains.
        idr_pct = 0;
        run(20);
        idr_pct = 100;
        run(20);

        // 4: redirect while a response is pending.
        min_delay = 2; max_delay = 3;
        n = 0;
        while (!(outstanding && !(mem_busy && mem_delay == 0)) && n < 100) begin cycle(); n++; end
        check_bound("wait_t4", n, 100);
        redirect_once(32'h100);
        run(20);
        check_deq("redir_wait_pc", 0, 32'h100);

        // 5: redirect coinciding with a response and a decode handshake.
        idr_pct = 40; min_delay = 1; max_delay = 3;
        n = 0;
        while (!(outstanding && mem_busy && mem_delay == 0 && q.size() > 0) && n < 400) begin
            cycle(); n++;
        end
        check_bound("wait_t5", n, 400);
        k_idr_force = 1;
        redirect_once(32'h200);
        idr_pct = 100;
        run(20);
        check_deq("redir_rsp_pc", 0, 32'h200);

        // 6: reset while waiting with three entries queued; late response ignored.
        idr_pct = 0; min_delay = 3; max_delay = 4;
        n = 0;
        while (!(q.size() == 3 && outstanding) && n < 200) begin cycle(); n++; end
        check_bound("wait_t6", n, 200);
        k_rst = 1;
        cycle();
        k_rst = 0;
        k_chk_zero = 1;
        dut_deq.delete();
        cycle();
        k_chk_zero = 0;
        idr_pct = 100; min_delay = 0; max_delay = 1;
        run(30);
        check_deq("rst_restart_pc", 0, 32'h0);

        // PC wrap-around through the top of the address space.
        redirect_once(32'hFFFF_FFF8);
        run(30);
        check_deq("wrap_pc0", 0, 32'hFFFF_FFF8);
        check_deq("wrap_pc1", 1, 32'hFFFF_FFFC);
        check_deq("wrap_pc2", 2, 32'h0000_0000);

        // Randomized traffic: back-pressure, redirects, stray responses, resets.
        ready_pct = 70; idr_pct = 60; min_delay = 0; max_delay = 3;
        for (int i = 0; i < 1500; i++) begin
            k_redirect    = ($urandom_range(99) < 4);
            k_redirect_pc = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            k_rst         = ($urandom_range(499) == 0);
            k_junk        = ($urandom_range(19) == 0);
            k_idr_force   = 0;
            cycle();
        end
        k_redirect = 0; k_rst = 0; k_junk = 0;
        run(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
